// File: rtl/nanorv32_csr_counters_pkg.sv
// Shared CSR address map and decode helpers for the Nanorv32 counter block.
package nanorv32_csr_counters_pkg;

  localparam int CSR_ADDR_W = 12;

  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [CSR_ADDR_W-1:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE         = 12'hC00;
  localparam logic [CSR_ADDR_W-1:0] CSR_TIME          = 12'hC01;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [CSR_ADDR_W-1:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [CSR_ADDR_W-1:0] CSR_HI_OFS        = 12'h080;

  typedef enum logic [1:0] {
    SPACE_NONE,
    SPACE_MCNT,   // 0xB00-0xB1F / 0xB80-0xB9F
    SPACE_UCNT,   // 0xC00-0xC1F / 0xC80-0xC9F
    SPACE_MCFG    // 0x320-0x33F
  } csr_space_e;

  function automatic csr_space_e csr_space(input logic [CSR_ADDR_W-1:0] a);
    if (a[11:8] == CSR_MCYCLE[11:8] && a[6:5] == 2'b00) return SPACE_MCNT;
    if (a[11:8] == CSR_CYCLE[11:8]  && a[6:5] == 2'b00) return SPACE_UCNT;
    if (a[11:5] == CSR_MCOUNTINHIBIT[11:5])             return SPACE_MCFG;
    return SPACE_NONE;
  endfunction

endpackage

// File: rtl/nanorv32_csr_counter.sv
// One wrapping counter with independent 32-bit low/high half writes.
module nanorv32_csr_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] value
);

  logic [CNT_WIDTH-1:0] value_q, value_d;
  logic                 unused_wdata;

  // A write replaces its half and suppresses that cycle's increment.
  always_comb begin
    value_d = value_q;
    if (wr_lo)      value_d = {value_q[CNT_WIDTH-1:32], wdata};
    else if (wr_hi) value_d = {wdata[CNT_WIDTH-33:0], value_q[31:0]};
    else if (inc)   value_d = value_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value        = value_q;
  assign unused_wdata = ^wdata;

endmodule

// File: rtl/nanorv32_csr_counters.sv
// cycle/time/instret/HPM counters with inhibit and event selectors; reads are
// combinational from the address, writes take effect at the next edge.
module nanorv32_csr_counters
  import nanorv32_csr_counters_pkg::*;
#(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8,
  parameter int EVT_W      = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CSR_ADDR_W-1:0] core_csr_addr,
  input  logic [31:0]           core_csr_wdata,
  input  logic                  core_csr_write,
  output logic [31:0]           csr_core_rdata,
  output logic                  csr_core_hit,
  input  logic                  force_stall_reset,
  input  logic                  stall_exe,
  input  logic [NUM_EVENTS-1:0] hpm_event
);

  localparam int NC  = 2 + NUM_HPM;
  localparam int NHA = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

  logic [NC-1:0][CNT_WIDTH-1:0] cnt;
  logic [NC-1:0]                cnt_inc, cnt_wr_lo, cnt_wr_hi, cnt_oh;
  logic [31:0]                  inhibit_q, inhibit_d;
  logic [NHA-1:0][EVT_W-1:0]    evt_q, evt_d;
  logic [NHA-1:0]               evt_sel;
  csr_space_e                   space;
  logic [4:0]                   idx;
  logic                         is_hi, m_wr;
  logic [63:0]                  cnt_rd;

  assign space = csr_space(core_csr_addr);
  assign idx   = core_csr_addr[4:0];
  assign is_hi = |(core_csr_addr & CSR_HI_OFS);

  // Slot 0 = cycle (also time), slot 1 = instret, slot 2+k = mhpmcounter(3+k).
  always_comb begin
    cnt_oh = '0;
    if (space == SPACE_MCNT || space == SPACE_UCNT) begin
      cnt_oh[0] = (idx == CSR_MCYCLE[4:0]) ||
                  (space == SPACE_UCNT && idx == CSR_TIME[4:0]);
      cnt_oh[1] = (idx == CSR_MINSTRET[4:0]);
      for (int k = 0; k < NUM_HPM; k++)
        cnt_oh[2+k] = (idx == CSR_MHPMCOUNTER3[4:0] + 5'(k));
    end
  end

  assign m_wr      = core_csr_write && (space == SPACE_MCNT);
  assign cnt_wr_lo = (m_wr && !is_hi) ? cnt_oh : '0;
  assign cnt_wr_hi = (m_wr &&  is_hi) ? cnt_oh : '0;

  // Selector value v picks hpm_event[v-1]; 0 and out-of-range values select nothing.
  always_comb begin
    evt_sel = '0;
    for (int k = 0; k < NUM_HPM; k++)
      for (int j = 0; j < NUM_EVENTS; j++)
        if (evt_q[k] == EVT_W'(j + 1)) evt_sel[k] = hpm_event[j];
    cnt_inc    = '0;
    cnt_inc[0] = !force_stall_reset && !inhibit_q[0];
    cnt_inc[1] = !force_stall_reset && !stall_exe && !inhibit_q[2];
    for (int k = 0; k < NUM_HPM; k++)
      cnt_inc[2+k] = !force_stall_reset && !inhibit_q[3+k] && evt_sel[k];
  end

  always_comb begin
    inhibit_d = inhibit_q;
    evt_d     = evt_q;
    if (core_csr_write && space == SPACE_MCFG) begin
      if (idx == CSR_MCOUNTINHIBIT[4:0]) inhibit_d = core_csr_wdata & INH_MASK;
      for (int k = 0; k < NUM_HPM; k++)
        if (idx == CSR_MHPMEVENT3[4:0] + 5'(k)) evt_d[k] = core_csr_wdata[EVT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inhibit_q <= '0;
      evt_q     <= '0;
    end else begin
      inhibit_q <= inhibit_d;
      evt_q     <= evt_d;
    end
  end

  for (genvar g = 0; g < NC; g++) begin : g_cnt
    nanorv32_csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc[g]),
      .wr_lo (cnt_wr_lo[g]),
      .wr_hi (cnt_wr_hi[g]),
      .wdata (core_csr_wdata),
      .value (cnt[g])
    );
  end

  // Counters are zero-extended to 64 bits so unimplemented high bits read 0.
  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < NC; i++)
      if (cnt_oh[i]) cnt_rd = 64'(cnt[i]);
    csr_core_hit   = |cnt_oh;
    csr_core_rdata = is_hi ? cnt_rd[63:32] : cnt_rd[31:0];
    if (space == SPACE_MCFG) begin
      if (idx == CSR_MCOUNTINHIBIT[4:0]) begin
        csr_core_hit   = 1'b1;
        csr_core_rdata = inhibit_q;
      end
      for (int k = 0; k < NUM_HPM; k++)
        if (idx == CSR_MHPMEVENT3[4:0] + 5'(k)) begin
          csr_core_hit   = 1'b1;
          csr_core_rdata = 32'(evt_q[k]);
        end
    end
  end

endmodule

// File: tb/tb_nanorv32_csr_counters.sv
// Directed + random bench for nanorv32_csr_counters against an architectural model.
module tb_nanorv32_csr_counters;

  localparam int NHPM = 4;
  localparam int NEV  = 8;

  logic        clk;
  logic        rst;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_write;
  logic [31:0] rdata;
  logic        hit;
  logic        fsr;
  logic        stall;
  logic [NEV-1:0] hpm_event;

  int checks = 0;
  int errors = 0;

  // Architectural state indexed by CSR counter number N (0 = cycle, 2 = instret, 3.. = HPM).
  logic [63:0] m_cnt [32];
  logic [31:0] m_inh;
  int          m_evt [32];

  nanorv32_csr_counters #(.NUM_HPM(NHPM), .CNT_WIDTH(64), .NUM_EVENTS(NEV)) dut (
    .clk               (clk),
    .rst               (rst),
    .core_csr_addr     (csr_addr),
    .core_csr_wdata    (csr_wdata),
    .core_csr_write    (csr_write),
    .csr_core_rdata    (rdata),
    .csr_core_hit      (hit),
    .force_stall_reset (fsr),
    .stall_exe         (stall),
    .hpm_event         (hpm_event)
  );

  always #50 clk = ~clk;

  function automatic logic is_cnt(input int n);
    return n == 0 || n == 2 || (n >= 3 && n < 3 + NHPM);
  endfunction

  // Apply one clock edge of architectural behaviour to the model.
  task automatic model_edge();
    logic inc [32];
    logic wr  [32];
    if (rst) begin
      for (int n = 0; n < 32; n++) begin m_cnt[n] = '0; m_evt[n] = 0; end
      m_inh = '0;
      return;
    end
    for (int n = 0; n < 32; n++) begin inc[n] = 1'b0; wr[n] = 1'b0; end
    inc[0] = !fsr && !m_inh[0];
    inc[2] = !fsr && !stall && !m_inh[2];
    for (int n = 3; n < 3 + NHPM; n++)
      inc[n] = !fsr && !m_inh[n] && m_evt[n] >= 1 && m_evt[n] <= NEV && hpm_event[m_evt[n]-1];
    if (csr_write) begin
      for (int n = 0; n < 32; n++) if (is_cnt(n)) begin
        if (int'(csr_addr) == 'hB00 + n) begin m_cnt[n][31:0]  = csr_wdata; wr[n] = 1'b1; end
        if (int'(csr_addr) == 'hB80 + n) begin m_cnt[n][63:32] = csr_wdata; wr[n] = 1'b1; end
      end
    end
    for (int n = 0; n < 32; n++) if (!wr[n] && inc[n]) m_cnt[n] = m_cnt[n] + 64'd1;
    if (csr_write && csr_addr == 12'h320) m_inh = csr_wdata & 32'h7D;
    if (csr_write && int'(csr_addr) >= 'h323 && int'(csr_addr) < 'h323 + NHPM)
      m_evt[int'(csr_addr) - 'h320] = int'(csr_wdata[3:0]);
  endtask

  task automatic mread(input logic [11:0] a, output logic [31:0] d, output logic h);
    int n;
    logic [63:0] v;
    n = int'(a[4:0]);
    d = '0;
    h = 1'b0;
    if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00) begin
      if (is_cnt(n) || (n == 1 && a[11:8] == 4'hC)) begin
        h = 1'b1;
        v = m_cnt[(n == 1) ? 0 : n];
        d = a[7] ? v[63:32] : v[31:0];
      end
    end else if (a == 12'h320) begin
      h = 1'b1;
      d = m_inh;
    end else if (int'(a) >= 'h323 && int'(a) < 'h323 + NHPM) begin
      h = 1'b1;
      d = 32'(m_evt[int'(a) - 'h320]);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr = a; csr_wdata = d; csr_write = 1'b1;
    step();
    csr_write = 1'b0;
  endtask

  task automatic rd_const(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic rd_model(input string tag, input logic [11:0] a);
    logic [31:0] d;
    logic        h;
    csr_addr = a;
    #1;
    mread(a, d, h);
    chk({tag, ".data"}, rdata, d);
    chk({tag, ".hit"}, 32'(hit), 32'(h));
  endtask

  initial begin
    logic [63:0] c0, i0, h0, tmp;
    logic [31:0] pre_d;
    logic        pre_h;
    logic [11:0] wlist [$];
    logic [11:0] rlist [$];

    wlist = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
              12'hB83, 12'hB86, 12'hC00, 12'hC02, 12'h320, 12'h323, 12'h324, 12'h325,
              12'h326, 12'hB01, 12'hB07, 12'h7FF};
    rlist = '{12'hB00, 12'hB80, 12'hB01, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05,
              12'hB06, 12'hB07, 12'hB84, 12'hC00, 12'hC01, 12'hC81, 12'hC02, 12'hC05,
              12'hC86, 12'h320, 12'h321, 12'h323, 12'h326, 12'h327, 12'h7FF};

    clk = 1'b0; rst = 1'b1; csr_addr = '0; csr_wdata = '0; csr_write = 1'b0;
    fsr = 1'b0; stall = 1'b0; hpm_event = '0;
    step(); step();
    rst = 1'b0;

    rd_const("rst.mcycle", 12'hB00, 32'd0);
    rd_const("rst.mcycleh", 12'hB80, 32'd0);
    rd_const("rst.minstret", 12'hB02, 32'd0);
    rd_const("rst.hpm3", 12'hB03, 32'd0);
    rd_const("rst.inhibit", 12'h320, 32'd0);
    rd_const("rst.evt3", 12'h323, 32'd0);

    repeat (10) step();
    rd_const("idle.cycle", 12'hC00, 32'd10);
    rd_const("idle.time", 12'hC01, 32'd10);
    rd_const("idle.instret", 12'hC02, 32'd10);
    rd_const("idle.hpm3", 12'hB03, 32'd0);
    rd_const("idle.hpm6", 12'hB06, 32'd0);
    rd_model("idle.time_eq_cycle", 12'hC01);

    csr_wr(12'hB00, 32'hFFFF_FFFE);
    csr_wr(12'hB80, 32'h0);
    repeat (3) step();
    rd_const("carry.lo", 12'hB00, 32'h1);
    rd_const("carry.hi", 12'hB80, 32'h1);
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    csr_wr(12'hB80, 32'hFFFF_FFFF);
    step();
    rd_const("wrap.lo", 12'hB00, 32'h0);
    rd_const("wrap.hi", 12'hB80, 32'h0);

    csr_wr(12'h323, 32'd2);
    for (int i = 0; i < 12; i++) begin
      hpm_event = (i < 5) ? 8'b10 : 8'b01;
      step();
    end
    hpm_event = '0;
    rd_const("hpm.sel1", 12'hB03, 32'd5);
    csr_wr(12'h323, 32'(NEV + 1));
    hpm_event = '1;
    repeat (5) step();
    rd_const("hpm.oor_frozen", 12'hB03, 32'd5);
    rd_const("hpm.evt_rd", 12'h323, 32'(NEV + 1));

    csr_wr(12'h323, 32'd1);
    csr_wr(12'h320, 32'h5);
    c0 = m_cnt[0]; i0 = m_cnt[2]; h0 = m_cnt[3];
    repeat (6) step();
    rd_const("inh.cycle", 12'hB00, c0[31:0]);
    rd_const("inh.instret", 12'hB02, i0[31:0]);
    tmp = h0 + 64'd6;
    rd_const("inh.hpm3", 12'hB03, tmp[31:0]);
    csr_wr(12'h320, 32'h2);
    rd_const("inh.bit1", 12'h320, 32'h0);
    csr_wr(12'h320, 32'hFFFF_FFFF);
    rd_const("inh.mask", 12'h320, 32'h7D);
    csr_wr(12'h320, 32'h0);
    hpm_event = '0;

    c0 = m_cnt[0]; i0 = m_cnt[2];
    for (int i = 0; i < 10; i++) begin
      stall = (i < 4);
      step();
    end
    stall = 1'b0;
    tmp = c0 + 64'd10;
    rd_const("stall.cycle", 12'hB00, tmp[31:0]);
    tmp = i0 + 64'd6;
    rd_const("stall.instret", 12'hB02, tmp[31:0]);

    fsr = 1'b1; hpm_event = '1;
    c0 = m_cnt[0]; i0 = m_cnt[2]; h0 = m_cnt[3];
    repeat (5) step();
    fsr = 1'b0; hpm_event = '0;
    rd_const("fsr.cycle", 12'hB00, c0[31:0]);
    rd_const("fsr.instret", 12'hB02, i0[31:0]);
    rd_const("fsr.hpm3", 12'hB03, h0[31:0]);

    csr_addr = 12'hC00; csr_wdata = 32'h1234; csr_write = 1'b1;
    #1;
    chk("ro.hit", 32'(hit), 32'd1);
    step();
    csr_write = 1'b0;
    rd_model("ro.ignored", 12'hC00);

    csr_addr = 12'hB02; csr_wdata = 32'hABCD; csr_write = 1'b1;
    #1;
    mread(12'hB02, pre_d, pre_h);
    chk("wr.prewrite_read", rdata, pre_d);
    step();
    csr_write = 1'b0;
    rd_const("wr.exact", 12'hB02, 32'hABCD);
    rd_model("wr.hi_kept", 12'hB82);
    rd_const("unmapped.data", 12'h7FF, 32'h0);
    #1;
    chk("unmapped.hit", 32'(hit), 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [11:0] wa;
      hpm_event = NEV'($urandom);
      stall     = ($urandom_range(0, 3) == 0);
      fsr       = ($urandom_range(0, 19) == 0);
      csr_write = ($urandom_range(0, 4) == 0);
      wa        = wlist[$urandom_range(0, wlist.size() - 1)];
      csr_addr  = wa;
      csr_wdata = (wa[11:8] == 4'h3 && wa != 12'h320) ? 32'($urandom_range(0, 15)) : $urandom;
      step();
      csr_write = 1'b0;
      if ($urandom_range(0, 3) == 0) rd_model("rand.any", 12'($urandom_range(0, 4095)));
      else                           rd_model("rand.map", rlist[$urandom_range(0, rlist.size() - 1)]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
